// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- UART transmitter with an integrated TX FIFO.
//
// Words accepted on a valid/ready interface are queued in the FIFO. They are
// sent back-to-back as frames: a start bit, DATA_WIDTH data bits LSB first,
// an optional parity bit, then STOP_BITS stop bits. Each bit lasts OVERSAMPLE
// pulses of the shared sample_tick strobe.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   sample_tick  1-cycle strobe at OVERSAMPLE x baud
//   s_data       word to send
//   s_valid      s_data valid
//   s_ready      FIFO can accept (registered); transfer on s_valid & s_ready
//   parity_mode  00 none, 01 even, 10 odd, 11 none (latched per frame)
//   tx           serial output, idle high (registered)
//   busy         frame in progress or FIFO non-empty (registered)
//   tx_done      1-cycle pulse at the end of each frame (registered)
//   fifo_count   FIFO occupancy 0..FIFO_DEPTH (registered)
//   cts_n        clear-to-send, active low; only present when UART_TX_CTS_EN is
//                defined. Without the macro the block acts as if cts_n were 0.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [1:0]                  parity_mode,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef UART_TX_CTS_EN
  ,
  input  logic                        cts_n
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg, count_next;
  logic                  s_ready_reg;
  logic                  push, pop;

  assign push = s_valid & s_ready_reg;

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= s_data;
  end

  // Pointers are AW bits wide, so they wrap modulo the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      s_ready_reg <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg   <= count_next;
      s_ready_reg <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  // ------------------------------------------------------ flow control
  logic cts_ok;
`ifdef UART_TX_CTS_EN
  // Two-flop synchroniser; resets to "not clear" so nothing leaves until
  // cts_n has been seen low twice.
  logic [1:0] cts_sync_reg;
  always_ff @(posedge clk) begin
    if (rst) cts_sync_reg <= 2'b11;
    else     cts_sync_reg <= {cts_sync_reg[0], cts_n};
  end
  assign cts_ok = ~cts_sync_reg[1];
`else
  assign cts_ok = 1'b1;
`endif

  // ---------------------------------------------------------------- FSM
  state_t                state_reg, state_next;
  logic [TW-1:0]         tick_reg, tick_next;
  logic [3:0]            bit_reg, bit_next;
  logic                  stop_reg, stop_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_bit_reg, par_bit_next;
  logic                  tx_reg, tx_next;
  logic                  done_reg, done_next;
  logic                  busy_reg;
  logic                  bit_end, can_start, load;

  assign bit_end   = sample_tick & (tick_reg == TW'(OVERSAMPLE - 1));
  assign can_start = (count_reg != '0) & cts_ok;

  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    bit_next     = bit_reg;
    stop_next    = stop_reg;
    shift_next   = shift_reg;
    par_en_next  = par_en_reg;
    par_bit_next = par_bit_reg;
    done_next    = 1'b0;
    load         = 1'b0;
    pop          = 1'b0;
    tx_next      = 1'b1;

    if (state_reg != IDLE) begin
      if (bit_end)          tick_next = '0;
      else if (sample_tick) tick_next = tick_reg + TW'(1);
    end

    unique case (state_reg)
      IDLE: if (can_start) load = 1'b1;
      START: if (bit_end) begin
        state_next = DATA;
        bit_next   = '0;
      end
      DATA: if (bit_end) begin
        shift_next = shift_reg >> 1;
        if (bit_reg == 4'(DATA_WIDTH - 1)) begin
          state_next = par_en_reg ? PARITY : STOP;
          stop_next  = 1'b0;
        end else begin
          bit_next = bit_reg + 4'd1;
        end
      end
      PARITY: if (bit_end) begin
        state_next = STOP;
        stop_next  = 1'b0;
      end
      STOP: if (bit_end) begin
        if (stop_reg == 1'(STOP_BITS - 1)) begin
          done_next = 1'b1;
          // Chain straight into the next start bit when a word is waiting.
          if (can_start) load = 1'b1;
          else           state_next = IDLE;
        end else begin
          stop_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Pop the head and freeze its parity setting for the whole frame.
    if (load) begin
      pop          = 1'b1;
      state_next   = START;
      shift_next   = mem[rd_ptr_reg];
      par_en_next  = (parity_mode == 2'b01) | (parity_mode == 2'b10);
      par_bit_next = (parity_mode == 2'b10) ? ~^mem[rd_ptr_reg] : ^mem[rd_ptr_reg];
      tick_next    = '0;
      bit_next     = '0;
      stop_next    = 1'b0;
    end

    // tx is registered: drive the level belonging to the next state.
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_bit_next;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      bit_reg     <= '0;
      stop_reg    <= 1'b0;
      shift_reg   <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      tx_reg      <= 1'b1;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      bit_reg     <= bit_next;
      stop_reg    <= stop_next;
      shift_reg   <= shift_next;
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
      busy_reg    <= (state_next != IDLE) | (count_next != '0);
    end
  end

  assign s_ready    = s_ready_reg;
  assign tx         = tx_reg;
  assign tx_done    = done_reg;
  assign busy       = busy_reg;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- directed checks for uart_tx_fifo (DATA_WIDTH=8,
// STOP_BITS=1, OVERSAMPLE=16, FIFO_DEPTH=16, sample_tick every cycle unless
// a sequence says otherwise).
module tb_uart_tx_fifo;
  localparam int DW = 8;
  localparam int OS = 16;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst, sample_tick, s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic [1:0]    parity_mode;
  logic          tx, busy, tx_done;
  logic [CW-1:0] fifo_count;
`ifdef UART_TX_CTS_EN
  logic          cts_n;
`endif

  uart_tx_fifo #(.DATA_WIDTH(DW), .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .parity_mode(parity_mode), .tx(tx), .busy(busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
`ifdef UART_TX_CTS_EN
    , .cts_n(cts_n)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // frame: bit i is the i-th bit on the line (0 = start bit)
  typedef struct {
    logic [7:0]  data;
    logic [1:0]  mode;
    logic [1:0]  mid;
    int          len;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs [8];

  task automatic send_word(input logic [7:0] d, input logic [1:0] m);
    @(negedge clk);
    s_data = d; parity_mode = m; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_tx_low(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  // Called at the first negedge of a start bit; returns at the negedge just
  // after the frame, where tx_done is due.
  task automatic capture_frame(input int len, output logic [10:0] bits, output int glitches,
                               output int done_in, output logic done_end,
                               output logic tx_after, output logic busy_after);
    bits = '0; glitches = 0; done_in = 0;
    for (int i = 0; i < len * OS; i++) begin
      if (i > 0) @(negedge clk);
      if (i % OS == 0) bits[i / OS] = tx;
      else if (tx !== bits[i / OS]) glitches++;
      if (i > 0 && tx_done === 1'b1) done_in++;
    end
    @(negedge clk);
    done_end = tx_done; tx_after = tx; busy_after = busy;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [10:0] bits;
    int          gl, din;
    logic        dend, txa, ba;
    send_word(v.data, v.mode);
    check({tag, " tx high 1 cycle after write"}, tx, 1);
    @(negedge clk);
    check({tag, " tx low 2 cycles after write"}, tx, 0);
    parity_mode = v.mid;
    capture_frame(v.len, bits, gl, din, dend, txa, ba);
    $display("frame %s data=%02h mode=%0d bits=%03h", tag, v.data, v.mode, bits);
    check({tag, " frame bits"}, bits, v.frame);
    check({tag, " bit stability"}, gl, 0);
    check({tag, " tx_done in/at end"}, {din[15:0], 15'd0, dend}, {16'd0, 15'd0, 1'b1});
    check({tag, " idle after frame"}, {txa, ba}, 2'b10);
  endtask

  logic [7:0] burst [18];

  initial begin
    bit          ok, seen_full;
    int          lows, k;
    logic [10:0] bits;
    int          gl, din;
    logic        dend, txa, ba;

    vecs[0] = '{8'hA5, 2'b00, 2'b01, 10, 11'h34A};
    vecs[1] = '{8'h07, 2'b01, 2'b10, 11, 11'h60E};
    vecs[2] = '{8'h07, 2'b10, 2'b01, 11, 11'h40E};
    vecs[3] = '{8'h00, 2'b01, 2'b10, 11, 11'h400};
    vecs[4] = '{8'h00, 2'b10, 2'b00, 11, 11'h600};
    vecs[5] = '{8'hFF, 2'b11, 2'b01, 10, 11'h3FE};
    vecs[6] = '{8'h3C, 2'b10, 2'b01, 11, 11'h678};
    vecs[7] = '{8'h80, 2'b01, 2'b00, 11, 11'h700};
    for (int i = 0; i < 18; i++) burst[i] = 8'(8'h11 + i * 37);

    rst = 1'b1; sample_tick = 1'b1; s_valid = 1'b0; s_data = '0; parity_mode = 2'b00;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset tx", tx, 1);
    check("reset s_ready", s_ready, 1);
    check("reset busy", busy, 0);
    check("reset tx_done", tx_done, 0);
    check("reset fifo_count", fifo_count, 0);
    repeat (3) @(negedge clk);

    // Table: single frames, parity modes, mid-frame parity changes
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Burst of D+2 words while the first frame runs
    seen_full = 1'b0;
    fork
      begin
        k = 0;
        while (k < 18) begin
          @(negedge clk);
          if (s_ready) begin
            s_valid = 1'b1; s_data = burst[k]; parity_mode = 2'b00; k++;
          end else begin
            s_valid = 1'b0;
            if (!seen_full) begin
              seen_full = 1'b1;
              check("burst count at s_ready low", fifo_count, D);
            end
          end
        end
        @(negedge clk);
        s_valid = 1'b0;
      end
      begin
        wait_tx_low(10, ok);
        check("burst first start", ok, 1);
        for (int f = 0; f < 18; f++) begin
          capture_frame(10, bits, gl, din, dend, txa, ba);
          $display("burst frame %0d bits=%03h", f, bits);
          check($sformatf("burst%0d bits", f), bits, {1'b0, 1'b1, burst[f], 1'b0});
          check($sformatf("burst%0d stable+done", f), {gl[15:0], dend}, {16'd0, 1'b1});
          if (f < 17) check($sformatf("burst%0d no gap", f), txa, 0);
        end
      end
    join
    check("burst s_ready fell", seen_full, 1);
    check("burst drained", {busy, fifo_count}, 0);

    // Push and pop in the same cycle
    send_word(8'h5A, 2'b00);
    wait_tx_low(4, ok);
    check("pp frame A start", ok, 1);
    s_data = 8'hB1; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (158) @(negedge clk);
    check("pp count before", fifo_count, 1);
    s_data = 8'hC2; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("pp count after push+pop", fifo_count, 1);
    check("pp done and next start", {tx_done, tx}, 2'b10);
    wait_idle(1000, ok);
    check("pp drained", {ok, fifo_count}, {1'b1, 5'd0});

    // Reset during data bit 3
    send_word(8'h00, 2'b00);
    wait_tx_low(4, ok);
    s_data = 8'h55; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (69) @(negedge clk);
    check("rst pre tx (data bit 3)", {tx, fifo_count}, {1'b0, 5'd1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid tx", tx, 1);
    check("rst mid fifo_count", fifo_count, 0);
    check("rst mid busy/s_ready", {busy, s_ready}, 2'b01);
    lows = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    check("rst no resume", lows, 0);
    run_vec(vecs[0], "post-rst");

    // sample_tick held low: start bit does not advance
    sample_tick = 1'b0;
    send_word(8'h5B, 2'b00);
    wait_tx_low(4, ok);
    check("stall start", ok, 1);
    lows = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (tx === 1'b0) lows++; end
    check("stall start held", lows, 40);
    sample_tick = 1'b1;
    lows = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (tx === 1'b0) lows++; end
    check("stall resume start ticks", lows, 15);
    @(negedge clk);
    check("stall resume bit0", tx, 1);
    wait_idle(400, ok);
    check("stall drained", ok, 1);

`ifdef UART_TX_CTS_EN
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    send_word(8'hC3, 2'b00);
    send_word(8'h3C, 2'b00);
    lows = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    check("cts held tx", lows, 0);
    check("cts held busy/count", {busy, fifo_count}, {1'b1, 5'd2});
    cts_n = 1'b0;
    @(negedge clk); check("cts +1 tx", tx, 1);
    @(negedge clk); check("cts +2 tx", tx, 1);
    @(negedge clk); check("cts +3 tx", tx, 0);
    fork
      capture_frame(10, bits, gl, din, dend, txa, ba);
      begin repeat (30) @(negedge clk); cts_n = 1'b1; end
    join
    check("cts frame bits", bits, {1'b0, 1'b1, 8'hC3, 1'b0});
    check("cts frame stable+done", {gl[15:0], dend}, {16'd0, 1'b1});
    check("cts second held", {txa, ba, fifo_count}, {1'b1, 1'b1, 5'd1});
    cts_n = 1'b0;
    wait_idle(400, ok);
    check("cts drained", ok, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
